// File: rtl/branchpredictor_assoc.sv
// Set-associative branch predictor / BTB: combinational lookup on current_pc,
// execute-stage feedback updates counters, targets and round-robin victims.
module branchpredictor_assoc #(
  parameter int INDEX_BITS       = 2,
  parameter int WAYS             = 2,
  parameter int CTR_BITS         = 2,
  parameter bit ALLOC_TAKEN_ONLY = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic [31:0] current_pc,
  input  logic        feedback_enable,
  input  logic        feedback_branch_taken,
  input  logic [31:0] feedback_branch_addr,
  input  logic [31:0] feedback_current_pc,
  output logic [31:0] branch_addr,
  output logic        branch_taken,
  output logic        opinion
);

  localparam int SETS  = 1 << INDEX_BITS;
  localparam int TAG_W = 30 - INDEX_BITS;
  localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  localparam logic [CTR_BITS-1:0] CTR_MAX    = '1;
  localparam logic [CTR_BITS-1:0] CTR_WEAK_T = {1'b1, {(CTR_BITS-1){1'b0}}};
  localparam logic [CTR_BITS-1:0] CTR_WEAK_N = {1'b0, {(CTR_BITS-1){1'b1}}};

  logic                valid_reg  [SETS][WAYS];
  logic [TAG_W-1:0]    tag_reg    [SETS][WAYS];
  logic [29:0]         target_reg [SETS][WAYS];
  logic [CTR_BITS-1:0] ctr_reg    [SETS][WAYS];
  logic [WAY_W-1:0]    victim_reg [SETS];

  logic unused_low_bits;
  assign unused_low_bits = ^{current_pc[1:0], feedback_current_pc[1:0], feedback_branch_addr[1:0]};

  // ---------------- lookup ----------------
  logic [INDEX_BITS-1:0] lu_index;
  logic [TAG_W-1:0]      lu_tag;
  logic [WAYS-1:0]       lu_match;

  assign lu_index = current_pc[INDEX_BITS+1:2];
  assign lu_tag   = current_pc[31:INDEX_BITS+2];

  // ---------------- feedback ----------------
  logic [INDEX_BITS-1:0] fb_index;
  logic [TAG_W-1:0]      fb_tag;
  logic [WAYS-1:0]       fb_match;

  assign fb_index = feedback_current_pc[INDEX_BITS+1:2];
  assign fb_tag   = feedback_current_pc[31:INDEX_BITS+2];

  genvar gi;
  generate
    for (gi = 0; gi < WAYS; gi++) begin : g_match
      assign lu_match[gi] = valid_reg[lu_index][gi] && (tag_reg[lu_index][gi] == lu_tag);
      assign fb_match[gi] = valid_reg[fb_index][gi] && (tag_reg[fb_index][gi] == fb_tag);
    end
  endgenerate

  always_comb begin
    opinion      = 1'b0;
    branch_taken = 1'b0;
    branch_addr  = 32'd0;
    for (int w = 0; w < WAYS; w++) begin
      if (lu_match[w]) begin
        opinion      = 1'b1;
        branch_taken = ctr_reg[lu_index][w][CTR_BITS-1];
        branch_addr  = {target_reg[lu_index][w], 2'b00};
      end
    end
  end

  logic                fb_hit;
  logic [WAY_W-1:0]    fb_hit_way;
  logic                fb_has_free;
  logic [WAY_W-1:0]    fb_free_way;
  logic [WAY_W-1:0]    alloc_way;
  logic [WAY_W-1:0]    write_way;
  logic [CTR_BITS-1:0] hit_ctr;
  logic [CTR_BITS-1:0] ctr_next;
  logic                do_update;
  logic                do_alloc;

  // Descending scan so the lowest-numbered invalid way wins.
  always_comb begin
    fb_hit      = 1'b0;
    fb_hit_way  = '0;
    fb_has_free = 1'b0;
    fb_free_way = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (fb_match[w]) begin
        fb_hit     = 1'b1;
        fb_hit_way = WAY_W'(w);
      end
      if (!valid_reg[fb_index][w]) begin
        fb_has_free = 1'b1;
        fb_free_way = WAY_W'(w);
      end
    end
  end

  assign alloc_way = fb_has_free ? fb_free_way : victim_reg[fb_index];
  assign write_way = fb_hit ? fb_hit_way : alloc_way;
  assign hit_ctr   = ctr_reg[fb_index][fb_hit_way];
  assign do_update = feedback_enable && !flush;
  assign do_alloc  = do_update && !fb_hit && (!ALLOC_TAKEN_ONLY || feedback_branch_taken);

  always_comb begin
    ctr_next = hit_ctr;
    if (feedback_branch_taken) begin
      if (hit_ctr != CTR_MAX) ctr_next = hit_ctr + CTR_BITS'(1);
    end else begin
      if (hit_ctr != '0) ctr_next = hit_ctr - CTR_BITS'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < SETS; s++) begin
        victim_reg[s] <= '0;
        for (int w = 0; w < WAYS; w++) begin
          valid_reg[s][w] <= 1'b0;
          ctr_reg[s][w]   <= '0;
        end
      end
    end else if (flush) begin
      for (int s = 0; s < SETS; s++) begin
        victim_reg[s] <= '0;
        for (int w = 0; w < WAYS; w++) valid_reg[s][w] <= 1'b0;
      end
    end else if (do_update) begin
      if (fb_hit) begin
        ctr_reg[fb_index][fb_hit_way] <= ctr_next;
      end else if (do_alloc) begin
        valid_reg[fb_index][alloc_way] <= 1'b1;
        ctr_reg[fb_index][alloc_way]   <= feedback_branch_taken ? CTR_WEAK_T : CTR_WEAK_N;
        if (!fb_has_free && WAYS > 1) victim_reg[fb_index] <= victim_reg[fb_index] + WAY_W'(1);
      end
    end
  end

  // Tag and target carry no reset: they are meaningless while valid is clear.
  always_ff @(posedge clk) begin
    if (do_update && (fb_hit || do_alloc)) begin
      target_reg[fb_index][write_way] <= feedback_branch_addr[31:2];
      if (do_alloc) tag_reg[fb_index][write_way] <= fb_tag;
    end
  end

endmodule

// File: tb/tb_branchpredictor_assoc.sv
// Bench for branchpredictor_assoc: default config and allocate-on-taken-only config
// driven in parallel, checked every cycle against a table model plus literal expectations.
module tb_branchpredictor_assoc;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic [31:0] current_pc = 32'h0;
  logic        feedback_enable = 1'b0;
  logic        feedback_branch_taken = 1'b0;
  logic [31:0] feedback_branch_addr = 32'h0;
  logic [31:0] feedback_current_pc = 32'h0;

  logic [31:0] a0, a1;
  logic        t0, t1, o0, o1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  branchpredictor_assoc #(.INDEX_BITS(2), .WAYS(2), .CTR_BITS(2), .ALLOC_TAKEN_ONLY(1'b0)) dut (
    .clk(clk), .reset(reset), .flush(flush), .current_pc(current_pc),
    .feedback_enable(feedback_enable), .feedback_branch_taken(feedback_branch_taken),
    .feedback_branch_addr(feedback_branch_addr), .feedback_current_pc(feedback_current_pc),
    .branch_addr(a0), .branch_taken(t0), .opinion(o0));

  branchpredictor_assoc #(.INDEX_BITS(2), .WAYS(2), .CTR_BITS(2), .ALLOC_TAKEN_ONLY(1'b1)) dut_ato (
    .clk(clk), .reset(reset), .flush(flush), .current_pc(current_pc),
    .feedback_enable(feedback_enable), .feedback_branch_taken(feedback_branch_taken),
    .feedback_branch_addr(feedback_branch_addr), .feedback_current_pc(feedback_current_pc),
    .branch_addr(a1), .branch_taken(t1), .opinion(o1));

  // Model: 4 sets x 2 ways, counters as plain integers 0..3; index 0 = default, 1 = taken-only.
  bit          m_valid [2][4][2];
  int unsigned m_tag   [2][4][2];
  int unsigned m_tgt   [2][4][2];
  int          m_ctr   [2][4][2];
  int          m_vic   [2][4];

  task automatic model_clear(input bit counters_too);
    for (int c = 0; c < 2; c++)
      for (int s = 0; s < 4; s++) begin
        m_vic[c][s] = 0;
        for (int w = 0; w < 2; w++) begin
          m_valid[c][s][w] = 0;
          if (counters_too) m_ctr[c][s][w] = 0;
        end
      end
  endtask

  task automatic model_feedback(input int c, input int unsigned pc, input bit taken, input int unsigned tgt);
    int s, hit, way;
    s = (pc / 4) % 4;
    hit = -1;
    for (int w = 0; w < 2; w++)
      if (m_valid[c][s][w] && m_tag[c][s][w] == pc / 16) hit = w;
    if (hit >= 0) begin
      m_ctr[c][s][hit] = taken ? ((m_ctr[c][s][hit] < 3) ? m_ctr[c][s][hit] + 1 : 3)
                               : ((m_ctr[c][s][hit] > 0) ? m_ctr[c][s][hit] - 1 : 0);
      m_tgt[c][s][hit] = tgt / 4;
    end else if (!(c == 1 && !taken)) begin
      way = -1;
      for (int w = 1; w >= 0; w--) if (!m_valid[c][s][w]) way = w;
      if (way < 0) begin
        way = m_vic[c][s];
        m_vic[c][s] = (m_vic[c][s] + 1) % 2;
      end
      m_valid[c][s][way] = 1;
      m_tag[c][s][way]   = pc / 16;
      m_tgt[c][s][way]   = tgt / 4;
      m_ctr[c][s][way]   = taken ? 2 : 1;
    end
  endtask

  task automatic model_predict(input int c, input int unsigned pc, output bit op, output bit tk, output int unsigned addr);
    int s;
    s = (pc / 4) % 4;
    op = 0; tk = 0; addr = 0;
    for (int w = 0; w < 2; w++)
      if (m_valid[c][s][w] && m_tag[c][s][w] == pc / 16) begin
        op = 1;
        tk = (m_ctr[c][s][w] >= 2);
        addr = m_tgt[c][s][w] * 4;
      end
  endtask

  always @(posedge clk or posedge reset) begin
    if (reset) model_clear(1);
    else if (flush) model_clear(0);
    else if (feedback_enable) begin
      model_feedback(0, feedback_current_pc, feedback_branch_taken, feedback_branch_addr);
      model_feedback(1, feedback_current_pc, feedback_branch_taken, feedback_branch_addr);
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (pc=%h t=%0t)", name, act, exp, current_pc, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    bit op, tk;
    int unsigned addr;
    model_predict(0, current_pc, op, tk, addr);
    check("model_opinion", {31'd0, o0}, {31'd0, op});
    check("model_taken", {31'd0, t0}, {31'd0, tk});
    check("model_addr", a0, addr);
    model_predict(1, current_pc, op, tk, addr);
    check("model_ato_opinion", {31'd0, o1}, {31'd0, op});
    check("model_ato_taken", {31'd0, t1}, {31'd0, tk});
    check("model_ato_addr", a1, addr);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fb(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
    feedback_enable = 1'b1;
    feedback_current_pc = pc;
    feedback_branch_taken = taken;
    feedback_branch_addr = tgt;
    step();
    feedback_enable = 1'b0;
  endtask

  task automatic look(input string nm, input int d, input logic [31:0] pc,
                      input logic eo, input logic et, input logic [31:0] ea);
    current_pc = pc;
    #1;
    if (d == 0) begin
      check({nm, "_opinion"}, {31'd0, o0}, {31'd0, eo});
      check({nm, "_taken"}, {31'd0, t0}, {31'd0, et});
      check({nm, "_addr"}, a0, ea);
    end else begin
      check({nm, "_opinion"}, {31'd0, o1}, {31'd0, eo});
      check({nm, "_taken"}, {31'd0, t1}, {31'd0, et});
      check({nm, "_addr"}, a1, ea);
    end
  endtask

  initial begin
    current_pc = 32'h40;
    step(); step();
    look("in_reset", 0, 32'h40, 0, 0, 32'h0);
    reset = 1'b0;
    step();
    look("after_reset", 0, 32'h40, 0, 0, 32'h0);

    // allocation and tag check
    fb(32'h40, 1, 32'h100);
    look("alloc_hit", 0, 32'h40, 1, 1, 32'h100);
    look("other_tag", 0, 32'h50, 0, 0, 32'h0);
    look("low_bits", 0, 32'h42, 1, 1, 32'h100);

    // replacement in set 0
    fb(32'h50, 1, 32'h200);
    look("fill_w0", 0, 32'h40, 1, 1, 32'h100);
    look("fill_w1", 0, 32'h50, 1, 1, 32'h200);
    fb(32'h60, 1, 32'h300);
    look("evict_40", 0, 32'h40, 0, 0, 32'h0);
    look("keep_50", 0, 32'h50, 1, 1, 32'h200);
    look("new_60", 0, 32'h60, 1, 1, 32'h300);
    fb(32'h70, 1, 32'h400);
    look("evict_50", 0, 32'h50, 0, 0, 32'h0);
    look("keep_60", 0, 32'h60, 1, 1, 32'h300);
    look("new_70", 0, 32'h70, 1, 1, 32'h400);

    flush = 1'b1;
    step();
    flush = 1'b0;
    look("flushed", 0, 32'h60, 0, 0, 32'h0);

    // taken-only allocation, then counter walk
    fb(32'h40, 0, 32'h100);
    look("ato_nt_miss", 1, 32'h40, 0, 0, 32'h0);
    look("nt_alloc", 0, 32'h40, 1, 0, 32'h100);
    fb(32'h40, 1, 32'h100);
    look("ato_t_alloc", 1, 32'h40, 1, 1, 32'h100);
    look("ctr2", 0, 32'h40, 1, 1, 32'h100);
    fb(32'h40, 1, 32'h100);
    fb(32'h40, 1, 32'h100);
    look("ctr3", 0, 32'h40, 1, 1, 32'h100);
    fb(32'h40, 0, 32'h140);
    look("ctr3to2", 0, 32'h40, 1, 1, 32'h140);
    fb(32'h40, 0, 32'h140);
    look("ctr2to1", 0, 32'h40, 1, 0, 32'h140);
    fb(32'h80, 0, 32'h180);
    look("nt_miss_alloc", 0, 32'h80, 1, 0, 32'h180);
    look("ato_nt_80", 1, 32'h80, 0, 0, 32'h0);

    // same-cycle lookup and feedback: no bypass
    current_pc = 32'hC0;
    feedback_enable = 1'b1;
    feedback_current_pc = 32'hC0;
    feedback_branch_taken = 1'b1;
    feedback_branch_addr = 32'h500;
    look("same_cycle", 0, 32'hC0, 0, 0, 32'h0);
    step();
    feedback_enable = 1'b0;
    look("next_cycle", 0, 32'hC0, 1, 1, 32'h500);

    // flush beats feedback
    flush = 1'b1;
    feedback_enable = 1'b1;
    feedback_current_pc = 32'h44;
    feedback_branch_taken = 1'b1;
    feedback_branch_addr = 32'h600;
    step();
    flush = 1'b0;
    feedback_enable = 1'b0;
    look("flush_fb_44", 0, 32'h44, 0, 0, 32'h0);
    look("flush_fb_c0", 0, 32'hC0, 0, 0, 32'h0);
    look("flush_fb_80", 0, 32'h80, 0, 0, 32'h0);

    // asynchronous reset between edges
    fb(32'h40, 1, 32'h100);
    look("pre_async", 0, 32'h40, 1, 1, 32'h100);
    reset = 1'b1;
    look("async_reset", 0, 32'h40, 0, 0, 32'h0);
    reset = 1'b0;
    step();
    look("post_async", 0, 32'h40, 0, 0, 32'h0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/branchpredictor_assoc.md
Name: branchpredictor_assoc

Overview:
Parametrised set-associative branch predictor and branch target buffer for the fetch stage. Same lookup/feedback contract as the direct-mapped predictor, generalised in sets, ways and counter width, with full tag match, allocation with counter initialisation, round-robin replacement, flush and an allocation mode. Lookup is combinational on current_pc. Feedback from the execute stage updates state on the clock edge.

Parameters:
INDEX_BITS, 2, log2 of set count; sets = 2**INDEX_BITS (1..8).
WAYS, 2, associativity; power of two (1, 2, 4).
CTR_BITS, 2, saturating counter width (2..4).
ALLOC_TAKEN_ONLY, 0, 1 = allocate an entry only on a taken miss; 0 = allocate on any miss.

Ports:
clk  in  1  clock; all state updates on the rising edge.
reset  in  1  asynchronous, active-high; clears all valid bits, counters and replacement pointers.
flush  in  1  synchronous invalidate-all; has priority over feedback in the same cycle.
current_pc  in  32  fetch PC to predict.
feedback_enable  in  1  resolved-branch update strobe.
feedback_branch_taken  in  1  resolved direction.
feedback_branch_addr  in  32  resolved target.
feedback_current_pc  in  32  PC of the resolved branch.
branch_addr  out  32  predicted target; {stored_word_target, 2'b00} on hit, 0 on miss.
branch_taken  out  1  counter MSB on hit, 0 on miss.
opinion  out  1  1 when current_pc hits a valid entry.

Behaviour:
- Address split: word = pc[31:2]; pc[1:0] ignored. index = pc[INDEX_BITS+1:2]. tag = pc[31:INDEX_BITS+2].
- Entry fields: valid, tag, target[29:0], ctr[CTR_BITS-1:0]. Each set also holds a victim pointer of log2(WAYS) bits (0 bits when WAYS=1).
- Lookup (combinational): compare the tag against every valid way of the indexed set.
  - At most one way can match, because allocation never duplicates a tag.
  - Miss: all three outputs are 0.
- Reset (asynchronous): all valid=0, ctr=0, victim pointers=0. Outputs are therefore 0 during and after reset. Tag and target are don't-care.
- flush=1 at an edge: all valid=0 and victim pointers=0; the feedback in that cycle is discarded.
- Feedback, applied at the edge when feedback_enable=1 and flush=0, with fset = index of feedback_current_pc:
  - Hit in way w: ctr saturating-increments if taken (max 2**CTR_BITS-1) and decrements if not taken (min 0). Target is overwritten with feedback_branch_addr[31:2]. Victim pointer is unchanged.
  - Miss with ALLOC_TAKEN_ONLY=1 and not taken: no state change.
  - Otherwise allocate:
    - Way choice: the lowest-numbered invalid way in fset; if none, the way at the victim pointer, and the pointer then advances mod WAYS.
    - Written fields: valid=1, tag, target.
    - Counter initialised weakly toward the outcome: taken -> 2**(CTR_BITS-1); not taken -> 2**(CTR_BITS-1)-1.
    - Filling an invalid way does not move the pointer.
- Same-cycle lookup and feedback to the same PC: the lookup returns pre-update state; the update is visible from the next cycle. No bypass.
- Reset asserted mid-operation overrides any pending feedback or flush immediately.
- All feedback is single-cycle. There is no backpressure and feedback is always accepted.

Test Plan:
Config for all scenarios: INDEX_BITS=2, WAYS=2, CTR_BITS=2, ALLOC_TAKEN_ONLY=0 unless noted.
1. Reset: after reset, lookup 0x40 -> opinion=0, branch_taken=0, branch_addr=0.
2. Allocation and tag check: feedback pc=0x40, taken, target=0x100. Next cycle lookup 0x40 -> opinion=1, taken=1 (ctr=2), addr=0x100. Lookup 0x50 (same set 0, different tag) -> opinion=0. Lookup 0x42 -> hit (low bits ignored).
3. Replacement in set 0:
   - Allocate 0x40, then 0x50 (both ways filled, pointer still 0); both hit.
   - Allocate 0x60: evicts way 0 and the pointer becomes 1. Now 0x40 misses; 0x50 and 0x60 hit.
   - Allocate 0x70: evicts way 1 (0x50).
4. Counter saturation at 0x40:
   - Three taken feedbacks -> ctr=3.
   - One not-taken -> ctr=2, taken=1.
   - Second not-taken -> ctr=1, taken=0, opinion=1.
   - Not-taken miss at 0x80 -> ctr=1, predicts not taken.
5. ALLOC_TAKEN_ONLY=1: not-taken feedback at 0x40 -> still a miss. A taken feedback then allocates it.
6. Simultaneous events:
   - Feedback 0x40 taken with lookup 0x40 in the same cycle -> opinion=0 that cycle, 1 the next.
   - flush and feedback together -> all entries miss afterwards.
   - reset pulse between clock edges -> outputs drop to 0 without waiting for a clock edge.
